cpu_stack: RTL and testbench

Operand stack for the stack-machine CPU pipeline. Consumes the stage-5 stack-update bundle each cycle: a pop count, an optional push flag and a 35-bit push word. Applies pop-then-push atomically to an internal register-file stack. Presents registered top-of-stack (TOS) and next-on-stack (NOS) entries, current depth and sticky error flags back to the front of the pipeline.

---
 rtl/cpu_stack_if.sv | 25 ++
 rtl/cpu_stack.sv | 93 +++++++++
 tb/tb_cpu_stack.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_stack_if.sv
// Stage-5 stack-update bundle and the stack state returned to the front of the pipeline.
// The master drives the update; the slave (cpu_stack) returns TOS/NOS, depth and error flags.
interface cpu_stack_if #(
  parameter int unsigned DW = 7
);
  logic          push_5a;
  logic [10:0]   to_pop_5a;
  logic [34:0]   to_push_5a;
  logic          clr_err;
  logic [34:0]   tos;
  logic [34:0]   nos;
  logic [DW-1:0] depth;
  logic          underflow;
  logic          overflow;

  modport master (
    output push_5a, to_pop_5a, to_push_5a, clr_err,
    input  tos, nos, depth, underflow, overflow
  );

  modport slave (
    input  push_5a, to_pop_5a, to_push_5a, clr_err,
    output tos, nos, depth, underflow, overflow
  );
endinterface

// File: rtl/cpu_stack.sv
// Operand stack: atomic pop-then-push per cycle on a register-file stack,
// with registered TOS/NOS, depth and sticky underflow/overflow flags.
module cpu_stack #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 7
) (
  input  logic         clk,
  input  logic         rst,
  cpu_stack_if.slave   st
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (DW > 11) ? DW : 11;

  logic [34:0]   mem [DEPTH];

  logic [DW-1:0] depth_q, depth_d;
  logic [34:0]   tos_q, tos_d;
  logic [34:0]   nos_q, nos_d;
  logic          underflow_q, underflow_d;
  logic          overflow_q, overflow_d;

  logic [PW-1:0] pop_cnt;
  logic [PW-1:0] d_cur;
  logic [PW-1:0] d1;
  logic [DW-1:0] d1_n;
  logic          underflow_evt;
  logic          overflow_evt;
  logic          do_push;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] tos_idx;
  logic [AW-1:0] nos_idx;

  always_comb begin
    pop_cnt       = PW'(st.to_pop_5a);
    d_cur         = PW'(depth_q);
    underflow_evt = pop_cnt > d_cur;
    d1            = underflow_evt ? '0 : d_cur - pop_cnt;
    d1_n          = DW'(d1);
    do_push       = st.push_5a && (d1 < PW'(DEPTH));
    overflow_evt  = st.push_5a && !do_push;
    depth_d       = do_push ? d1_n + DW'(1) : d1_n;
    wr_idx        = AW'(d1_n);
    tos_idx       = AW'(depth_d - DW'(1));
    nos_idx       = AW'(depth_d - DW'(2));
  end

  // With a push, depth_d-2 == d1-1 and is below the write index, so the
  // pre-write memory read for NOS is exact in both the push and no-push case.
  always_comb begin
    tos_d = '0;
    nos_d = '0;
    if (do_push) begin
      tos_d = st.to_push_5a;
    end else if (depth_d >= DW'(1)) begin
      tos_d = mem[tos_idx];
    end
    if (depth_d >= DW'(2)) begin
      nos_d = mem[nos_idx];
    end
    underflow_d = underflow_evt || (underflow_q && !st.clr_err);
    overflow_d  = overflow_evt  || (overflow_q  && !st.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q     <= '0;
      tos_q       <= '0;
      nos_q       <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      tos_q       <= tos_d;
      nos_q       <= nos_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_idx] <= st.to_push_5a;
    end
  end

  assign st.tos       = tos_q;
  assign st.nos       = nos_q;
  assign st.depth     = depth_q;
  assign st.underflow = underflow_q;
  assign st.overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_stack.sv
// Directed bench for cpu_stack: push/pop sequences, underflow/overflow
// stickiness, full-stack boundaries and asynchronous reset mid-operation.
module tb_cpu_stack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cpu_stack_if #(.DW(7)) st_if ();

  cpu_stack #(.DEPTH(64), .DW(7)) dut (
    .clk (clk),
    .rst (rst),
    .st  (st_if)
  );

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] dep, input logic [34:0] tos,
                         input logic [34:0] nos, input logic uf, input logic ov);
    chk({tag, ".depth"}, 35'(st_if.depth), 35'(dep));
    chk({tag, ".tos"}, st_if.tos, tos);
    chk({tag, ".nos"}, st_if.nos, nos);
    chk({tag, ".uf"}, 35'(st_if.underflow), 35'(uf));
    chk({tag, ".ov"}, 35'(st_if.overflow), 35'(ov));
  endtask

  task automatic cyc(input logic push, input logic [10:0] pop, input logic [34:0] w, input logic clr);
    st_if.push_5a    = push;
    st_if.to_pop_5a  = pop;
    st_if.to_push_5a = w;
    st_if.clr_err    = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    st_if.push_5a    = 1'b0;
    st_if.to_pop_5a  = '0;
    st_if.to_push_5a = '0;
    st_if.clr_err    = 1'b0;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk_all("reset", 7'd0, 35'h0, 35'h0, 1'b0, 1'b0);

    cyc(1'b1, 11'd0, 35'h1, 1'b0);
    chk_all("push1", 7'd1, 35'h1, 35'h0, 1'b0, 1'b0);
    cyc(1'b1, 11'd0, 35'h2, 1'b0);
    chk_all("push2", 7'd2, 35'h2, 35'h1, 1'b0, 1'b0);
    cyc(1'b1, 11'd0, 35'h3, 1'b0);
    chk_all("push3", 7'd3, 35'h3, 35'h2, 1'b0, 1'b0);

    cyc(1'b1, 11'd2, 35'h7FFFFFFFF, 1'b0);
    chk_all("pop2push", 7'd2, 35'h7FFFFFFFF, 35'h1, 1'b0, 1'b0);
    cyc(1'b0, 11'd1, 35'h0, 1'b0);
    chk_all("pop1", 7'd1, 35'h1, 35'h0, 1'b0, 1'b0);

    cyc(1'b0, 11'd5, 35'h0, 1'b0);
    chk_all("pop5_uf", 7'd0, 35'h0, 35'h0, 1'b1, 1'b0);
    cyc(1'b0, 11'd0, 35'h0, 1'b1);
    chk("clr_uf", 35'(st_if.underflow), 35'h0);
    cyc(1'b0, 11'd5, 35'h0, 1'b1);
    chk("clr_vs_uf", 35'(st_if.underflow), 35'h1);
    cyc(1'b0, 11'd0, 35'h0, 1'b1);
    chk("clr_uf2", 35'(st_if.underflow), 35'h0);

    for (int i = 0; i < 64; i++) cyc(1'b1, 11'd0, 35'(i), 1'b0);
    chk_all("full", 7'd64, 35'd63, 35'd62, 1'b0, 1'b0);
    cyc(1'b1, 11'd0, 35'hAA, 1'b0);
    chk_all("ovf", 7'd64, 35'd63, 35'd62, 1'b0, 1'b1);
    cyc(1'b1, 11'd1, 35'hAA, 1'b0);
    chk_all("pop1push_full", 7'd64, 35'hAA, 35'd62, 1'b0, 1'b1);
    cyc(1'b1, 11'd0, 35'hBB, 1'b1);
    chk("clr_vs_ov", 35'(st_if.overflow), 35'h1);
    chk("ovf_tos_kept", st_if.tos, 35'hAA);

    cyc(1'b0, 11'd2047, 35'h0, 1'b0);
    chk_all("pop2047", 7'd0, 35'h0, 35'h0, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) cyc(1'b1, 11'd0, 35'(32'h100 + i), 1'b0);
    chk_all("depth10", 7'd10, 35'h109, 35'h108, 1'b1, 1'b1);

    st_if.push_5a    = 1'b1;
    st_if.to_push_5a = 35'h99;
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 7'd0, 35'h0, 35'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_hold", 7'd0, 35'h0, 35'h0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    cyc(1'b1, 11'd0, 35'h5, 1'b0);
    chk_all("post_rst_push", 7'd1, 35'h5, 35'h0, 1'b0, 1'b0);
    cyc(1'b0, 11'd0, 35'h0, 1'b0);
    chk_all("idle", 7'd1, 35'h5, 35'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
